layer_generator: RTL and testbench

LAYER_GENERATOR -- requirements
Module: layer_generator

---
 rtl/layer_generator.sv | 136 +++++++++++++
 tb/tb_layer_generator.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/layer_generator.sv
// Layer generator: LFSR-driven 7-column layers, 5 spaced preload pushes, then one layer per jump.
// Latency: jump to new outputs 1 cycle; all outputs registered; no backpressure, jumps outside RUN are dropped.
module layer_generator #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          LOAD_GAP  = 16,
  parameter int          START_COL = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       module_en,
  input  logic       jump_left,
  input  logic       jump_right,
  output logic [0:6] layer_map_out,
  output logic [0:6] block_type_out,
  output logic [0:6] bonus_map_out,
  output logic       load_layer,
  output logic       ready
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [2:0]  SC_INIT  = 3'(START_COL);
  localparam logic [7:0]  GAP_LAST = 8'(LOAD_GAP - 1);
  localparam logic [7:0]  GAP_GEN  = 8'(LOAD_GAP - 2);

  typedef enum logic [1:0] {IDLE, PRELOAD, RUN} state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [2:0]  sc_q, sc_d, sc_new;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  pulses_q, pulses_d;
  logic [0:6]  map_q, map_d, type_q, type_d, bonus_q, bonus_d;
  logic [0:6]  onehot, gen_map;
  logic        load_q, load_d, ready_q, ready_d;
  logic        gen, fb;

  always_comb begin
    fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    if (lfsr_q[0]) sc_new = (sc_q == 3'd6) ? 3'd6 : sc_q + 3'd1;
    else           sc_new = (sc_q == 3'd0) ? 3'd0 : sc_q - 3'd1;
    onehot = '0;
    onehot[sc_new] = 1'b1;
    gen_map = lfsr_q[7:1] | onehot;

    state_d  = state_q;
    lfsr_d   = lfsr_q;
    sc_d     = sc_q;
    cnt_d    = cnt_q;
    pulses_d = pulses_q;
    map_d    = map_q;
    type_d   = type_q;
    bonus_d  = bonus_q;
    load_d   = 1'b0;
    gen      = 1'b0;

    if (module_en) begin
      lfsr_d = {lfsr_q[14:0], fb};
      case (state_q)
        IDLE: begin
          state_d  = PRELOAD;
          cnt_d    = '0;
          pulses_d = '0;
        end
        PRELOAD: begin
          cnt_d = (cnt_q == GAP_LAST) ? 8'd0 : cnt_q + 8'd1;
          // The layer lands one cycle ahead of its pulse so the consumer sees it settled.
          if (cnt_q == GAP_GEN) gen = 1'b1;
          if (cnt_q == GAP_LAST) begin
            load_d   = 1'b1;
            pulses_d = pulses_q + 3'd1;
          end
          if (load_q && pulses_q == 3'd5) begin
            state_d = RUN;
            gen     = 1'b1;
          end
        end
        RUN: begin
          if (jump_left || jump_right) gen = 1'b1;
        end
        default: state_d = IDLE;
      endcase

      if (gen) begin
        sc_d    = sc_new;
        map_d   = gen_map;
        type_d  = (lfsr_q[14:8] | onehot) & gen_map;
        bonus_d = lfsr_q[15] ? (onehot & gen_map) : 7'b0;
      end
    end else begin
      // Disabling parks everything except the LFSR, which keeps its position.
      state_d  = IDLE;
      sc_d     = SC_INIT;
      cnt_d    = '0;
      pulses_d = '0;
      map_d    = '0;
      type_d   = '0;
      bonus_d  = '0;
    end

    ready_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED_EFF;
      sc_q     <= SC_INIT;
      cnt_q    <= '0;
      pulses_q <= '0;
      map_q    <= '0;
      type_q   <= '0;
      bonus_q  <= '0;
      load_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      sc_q     <= sc_d;
      cnt_q    <= cnt_d;
      pulses_q <= pulses_d;
      map_q    <= map_d;
      type_q   <= type_d;
      bonus_q  <= bonus_d;
      load_q   <= load_d;
      ready_q  <= ready_d;
    end
  end

  assign layer_map_out  = map_q;
  assign block_type_out = type_q;
  assign bonus_map_out  = bonus_q;
  assign load_layer     = load_q;
  assign ready          = ready_q;

endmodule

// File: tb/tb_layer_generator.sv
// Directed bench for layer_generator: preload timing, jump advance, enable/reset aborts, layer invariants.
module tb_layer_generator;

  localparam logic [15:0] SEED      = 16'hACE1;
  localparam int          GAP       = 16;
  localparam int          START_COL = 3;

  logic       clk = 1'b0;
  logic       rst, module_en, jump_left, jump_right;
  logic [0:6] layer_map_out, block_type_out, bonus_map_out;
  logic       load_layer, ready;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_lfsr;
  int          m_sc;
  int          hi_clamps = 0;
  int          lo_clamps = 0;
  logic [0:6]  e_map, e_type, e_bonus;
  logic [20:0] e_outs, prev_outs, outs;

  layer_generator #(.SEED(SEED), .LOAD_GAP(GAP), .START_COL(START_COL)) dut (
    .clk(clk), .rst(rst), .module_en(module_en),
    .jump_left(jump_left), .jump_right(jump_right),
    .layer_map_out(layer_map_out), .block_type_out(block_type_out),
    .bonus_map_out(bonus_map_out), .load_layer(load_layer), .ready(ready)
  );

  always #5 clk = ~clk;

  assign outs = {layer_map_out, block_type_out, bonus_map_out};

  // Reference LFSR: taps 16,14,13,11, advances only while enabled.
  always @(posedge clk) begin
    if (rst) m_lfsr <= SEED;
    else if (module_en) m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Predicts the layer built from the LFSR value of the current cycle.
  task automatic gen_expected();
    logic [0:6] oh;
    if (m_lfsr[0]) begin
      if (m_sc == 6) hi_clamps++; else m_sc++;
    end else begin
      if (m_sc == 0) lo_clamps++; else m_sc--;
    end
    oh = '0;
    oh[m_sc] = 1'b1;
    e_map   = m_lfsr[7:1] | oh;
    e_type  = (m_lfsr[14:8] | oh) & e_map;
    e_bonus = m_lfsr[15] ? (oh & e_map) : 7'b0;
    e_outs  = {e_map, e_type, e_bonus};
  endtask

  task automatic check_layer(input string tag);
    check(tag, 32'(outs), 32'(e_outs));
    check({tag, "_safe"}, 32'({layer_map_out[m_sc], block_type_out[m_sc]}), 32'd3);
    check({tag, "_subset"}, 32'((block_type_out & ~layer_map_out) | (bonus_map_out & ~layer_map_out)), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_outs"}, 32'(outs), 32'd0);
    check({tag, "_load"}, 32'(load_layer), 32'd0);
    check({tag, "_ready"}, 32'(ready), 32'd0);
  endtask

  // Called in cycle 0 of PRELOAD; walks to RUN unless dropped or reset at the given cycle.
  task automatic do_preload(input int drop_at, input int rst_at, input bit with_jumps);
    prev_outs = '0;
    for (int k = 0; k <= 81; k++) begin
      check("load_layer", 32'(load_layer), 32'((k > 0 && k % GAP == 0) ? 1 : 0));
      check("ready", 32'(ready), 32'((k == 81) ? 1 : 0));
      if (k == 81 || ((k + 1) % GAP == 0 && k < 80)) check_layer("preload_layer");
      else check("preload_hold", 32'(outs), 32'(prev_outs));
      if (k == 81) return;
      if (k == drop_at) begin
        module_en = 1'b0;
        tick();
        check_idle("drop");
        m_sc = START_COL;
        return;
      end
      if (k == rst_at) begin
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
          tick();
          check_idle("rst_abort");
        end
        rst = 1'b0;
        m_sc = START_COL;
        return;
      end
      if (with_jumps && (k == 20 || k == 31)) begin
        jump_left  = 1'b1;
        jump_right = (k == 31);
      end
      prev_outs = outs;
      if ((k + 2) % GAP == 0 || k == 80) gen_expected();
      tick();
      jump_left  = 1'b0;
      jump_right = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; module_en = 1'b0; jump_left = 1'b0; jump_right = 1'b0;
    m_sc = START_COL;
    tick();
    tick();
    check_idle("reset");

    // Reset wins over enable and jumps.
    module_en = 1'b1; jump_left = 1'b1;
    tick();
    check_idle("rst_override");
    jump_left = 1'b0;
    rst = 1'b0;
    tick();
    do_preload(-1, -1, 1'b0);

    // Single jump: new layer next cycle, then held.
    gen_expected();
    jump_left = 1'b1;
    tick();
    jump_left = 1'b0;
    check_layer("jump_single");
    check("run_no_load", 32'(load_layer), 32'd0);
    prev_outs = outs;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("run_hold", 32'(outs), 32'(prev_outs));
    end

    // Both jumps together are one advance.
    gen_expected();
    jump_left = 1'b1; jump_right = 1'b1;
    tick();
    jump_left = 1'b0; jump_right = 1'b0;
    check_layer("jump_both");
    tick();
    check("jump_both_hold", 32'(outs), 32'(e_outs));

    // Random jumps with random gaps.
    for (int i = 0; i < 1000; i++) begin
      int gap;
      int kind;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        prev_outs = outs;
        tick();
        check("rand_hold", 32'(outs), 32'(prev_outs));
      end
      kind = $urandom_range(0, 2);
      gen_expected();
      jump_left  = (kind != 1);
      jump_right = (kind != 0);
      tick();
      jump_left = 1'b0; jump_right = 1'b0;
      check_layer("rand_jump");
    end

    // Back-to-back jumps: one layer per cycle.
    for (int i = 0; i < 10000; i++) begin
      gen_expected();
      jump_right = 1'b1;
      tick();
      check_layer("burst_jump");
      check("burst_ready", 32'(ready), 32'd1);
    end
    jump_right = 1'b0;
    check("sc_clamp_hi_seen", 32'(hi_clamps > 0), 32'd1);
    check("sc_clamp_lo_seen", 32'(lo_clamps > 0), 32'd1);

    // Disable from RUN.
    module_en = 1'b0;
    tick();
    check_idle("disable_run");
    m_sc = START_COL;
    tick();
    check_idle("disable_hold");

    // Preload with ignored jumps, dropped after the third pulse.
    module_en = 1'b1;
    tick();
    do_preload(48, -1, 1'b1);
    tick();
    check_idle("drop_stay");

    // Fresh preload aborted by reset, then a clean restart to RUN.
    module_en = 1'b1;
    tick();
    do_preload(-1, 40, 1'b0);
    tick();
    do_preload(-1, -1, 1'b0);
    gen_expected();
    jump_right = 1'b1;
    tick();
    jump_right = 1'b0;
    check_layer("restart_jump");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
